es_harvest_ctrl: RTL and testbench

ES_HARVEST_CTRL -- requirements
Module: es_harvest_ctrl

---
 rtl/es_harvest_ctrl.sv | 143 ++++++++++++++
 tb/tb_es_harvest_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/es_harvest_ctrl.sv
// Entropy harvest controller: captures per-group source words with health masks into a
// ring, compacts the good bits LSB-first and emits OUT_W-bit words under valid/ready.
module es_harvest_ctrl #(
  parameter int NUM_GROUPS = 2,
  parameter int WORD_W     = 32,
  parameter int DEPTH      = 64,
  parameter int OUT_W      = 128,
  parameter int RD_THRESH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_GROUPS*WORD_W-1:0] es_in,
  input  logic [NUM_GROUPS*WORD_W-1:0] src_valid,
  input  logic [NUM_GROUPS*WORD_W-1:0] src_fail,
  input  logic                         sample_en,
  input  logic [NUM_GROUPS-1:0]        grp_en,
  input  logic                         raw_mode,
  input  logic                         drain,
  output logic [OUT_W-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH):0]       occupancy,
  output logic                         ring_full,
  output logic                         ring_empty,
  output logic [15:0]                  drop_cnt
);
  localparam int AW   = $clog2(DEPTH);
  localparam int GW   = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int AccW = OUT_W + WORD_W;
  localparam int CW   = $clog2(AccW + 1);

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [GW-1:0] next_grp(input logic [GW-1:0] cur,
                                             input logic [NUM_GROUPS-1:0] en);
    logic [GW-1:0] cand;
    next_grp = cur;
    // Descending scan so the nearest enabled index above cur wins.
    for (int i = NUM_GROUPS; i >= 1; i--) begin
      cand = GW'((int'(cur) + i) % NUM_GROUPS);
      if (en[cand]) next_grp = cand;
    end
  endfunction

  function automatic logic [WORD_W-1:0] compact(input logic [WORD_W-1:0] d,
                                                input logic [WORD_W-1:0] m);
    int k;
    compact = '0;
    k = 0;
    for (int i = 0; i < WORD_W; i++) begin
      if (m[i]) begin
        compact = compact | (WORD_W'(d[i]) << k);
        k++;
      end
    end
  endfunction

  logic [2*WORD_W-1:0] ring [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [AW:0]         occ;
  logic [GW-1:0]       gp;

  logic [WORD_W-1:0]   cap_data_p0, cap_mask_p0;
  logic                capture_p0, push_p0, drop_p0, pop_p0;

  logic [WORD_W-1:0]   stg_data_p1, stg_mask_p1;
  logic                vld_p1, consume_p1;

  logic [AccW-1:0]     acc_p2, acc_nxt_p2;
  logic [CW-1:0]       acc_cnt_p2, base_p2, cnt_nxt_p2;
  logic                emit_p2;

  assign occupancy  = occ;
  assign ring_full  = (occ == (AW+1)'(DEPTH));
  assign ring_empty = (occ == '0);

  always_comb begin
    cap_data_p0 = es_in[int'(gp)*WORD_W +: WORD_W];
    cap_mask_p0 = raw_mode ? '1
                           : (src_valid[int'(gp)*WORD_W +: WORD_W] &
                              ~src_fail[int'(gp)*WORD_W +: WORD_W]);
    capture_p0  = sample_en && grp_en[gp];

    emit_p2    = (acc_cnt_p2 >= CW'(OUT_W)) && (!out_valid || out_ready);
    base_p2    = emit_p2 ? acc_cnt_p2 - CW'(OUT_W) : acc_cnt_p2;
    consume_p1 = vld_p1 && (base_p2 < CW'(OUT_W));

    pop_p0  = ((occ >= (AW+1)'(RD_THRESH)) || (drain && occ != '0)) &&
              (!vld_p1 || consume_p1);
    push_p0 = capture_p0 && (!ring_full || pop_p0);
    drop_p0 = capture_p0 && ring_full && !pop_p0;

    acc_nxt_p2 = (emit_p2 ? (acc_p2 >> OUT_W) : acc_p2) |
                 (consume_p1 ? (AccW'(compact(stg_data_p1, stg_mask_p1)) << base_p2) : '0);
    cnt_nxt_p2 = base_p2 + (consume_p1 ? CW'($countones(stg_mask_p1)) : '0);
  end

  // p0: ring write; p1: registered ring read into the stage register
  always_ff @(posedge clk) begin
    if (push_p0) ring[wr_ptr] <= {cap_data_p0, cap_mask_p0};
    if (pop_p0)  {stg_data_p1, stg_mask_p1} <= ring[rd_ptr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      gp         <= '0;
      vld_p1     <= 1'b0;
      acc_p2     <= '0;
      acc_cnt_p2 <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      drop_cnt   <= '0;
    end else begin
      if (sample_en && grp_en != '0) gp <= next_grp(gp, grp_en);
      if (push_p0) wr_ptr <= wr_ptr + AW'(1);
      if (pop_p0)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_p0, pop_p0})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: ;
      endcase
      if (drop_p0) drop_cnt <= sat_inc16(drop_cnt);

      if (pop_p0)          vld_p1 <= 1'b1;
      else if (consume_p1) vld_p1 <= 1'b0;

      // p2: accumulator and output register
      acc_p2     <= acc_nxt_p2;
      acc_cnt_p2 <= cnt_nxt_p2;
      if (emit_p2) begin
        out_data  <= acc_p2[OUT_W-1:0];
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_es_harvest_ctrl.sv
// Bench for es_harvest_ctrl: directed scenarios plus randomized traffic, all compared
// cycle by cycle against a queue-based reference model of the harvest pipeline.
module tb_es_harvest_ctrl;
  localparam int NG  = 4;
  localparam int WW  = 32;
  localparam int DP  = 64;
  localparam int OW  = 128;
  localparam int RT  = 16;
  localparam int OCW = $clog2(DP) + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [NG*WW-1:0] es_in, src_valid, src_fail;
  logic           sample_en;
  logic [NG-1:0]  grp_en;
  logic           raw_mode, drain, out_ready;
  logic [OW-1:0]  out_data;
  logic           out_valid;
  logic [OCW-1:0] occupancy;
  logic           ring_full, ring_empty;
  logic [15:0]    drop_cnt;

  int n_chk = 0;
  int n_pass = 0;
  logic [OW-1:0] got_q[$];

  // Reference model state: ring as a queue of {data,mask}, accumulator as a bit queue.
  logic [2*WW-1:0] m_ring[$];
  logic [2*WW-1:0] m_stg;
  bit              m_stg_vld;
  bit              m_acc[$];
  logic [OW-1:0]   m_out;
  bit              m_ov;
  int              m_drop;
  int              m_gp;

  es_harvest_ctrl #(
    .NUM_GROUPS(NG), .WORD_W(WW), .DEPTH(DP), .OUT_W(OW), .RD_THRESH(RT)
  ) dut (
    .clk(clk), .rst(rst), .es_in(es_in), .src_valid(src_valid), .src_fail(src_fail),
    .sample_en(sample_en), .grp_en(grp_en), .raw_mode(raw_mode), .drain(drain),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .occupancy(occupancy), .ring_full(ring_full), .ring_empty(ring_empty),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
  endtask

  task automatic m_step();
    bit emit, cons, pop, cap, full, en_bit;
    int rem, nxt;
    logic [WW-1:0] d, msk;
    if (rst) begin
      m_ring.delete(); m_acc.delete();
      m_stg_vld = 0; m_out = '0; m_ov = 0; m_drop = 0; m_gp = 0;
      return;
    end
    emit = (m_acc.size() >= OW) && (!m_ov || out_ready);
    rem  = m_acc.size() - (emit ? OW : 0);
    cons = m_stg_vld && (rem < OW);
    pop  = ((m_ring.size() >= RT) || (drain && m_ring.size() > 0)) && (!m_stg_vld || cons);
    en_bit = ((grp_en >> m_gp) & NG'(1)) != '0;
    cap  = sample_en && en_bit;
    full = (m_ring.size() == DP);
    d    = es_in[m_gp*WW +: WW];
    msk  = raw_mode ? '1 : (src_valid[m_gp*WW +: WW] & ~src_fail[m_gp*WW +: WW]);

    if (emit) begin
      for (int i = 0; i < OW; i++) m_out[i] = m_acc.pop_front();
      m_ov = 1;
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (cons) begin
      for (int i = 0; i < WW; i++) if (m_stg[i]) m_acc.push_back(m_stg[WW+i]);
      m_stg_vld = 0;
    end
    if (pop) begin
      m_stg = m_ring.pop_front();
      m_stg_vld = 1;
    end
    if (cap) begin
      if (!full || pop) m_ring.push_back({d, msk});
      else if (m_drop < 65535) m_drop++;
    end
    if (sample_en && grp_en != '0) begin
      nxt = m_gp;
      for (int k = NG; k >= 1; k--)
        if (((grp_en >> ((m_gp + k) % NG)) & NG'(1)) != '0) nxt = (m_gp + k) % NG;
      m_gp = nxt;
    end
  endtask

  task automatic compare_all();
    chk("occupancy",  OW'(occupancy),  OW'(m_ring.size()));
    chk("ring_full",  OW'(ring_full),  OW'(m_ring.size() == DP));
    chk("ring_empty", OW'(ring_empty), OW'(m_ring.size() == 0));
    chk("out_valid",  OW'(out_valid),  OW'(m_ov));
    chk("out_data",   out_data,        m_out);
    chk("drop_cnt",   OW'(drop_cnt),   OW'(m_drop));
  endtask

  task automatic step();
    @(posedge clk);
    m_step();
    #1;
    compare_all();
    if (out_valid && out_ready) got_q.push_back(out_data);
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic capture_n(input int n);
    sample_en = 1'b1;
    repeat (n) step();
    sample_en = 1'b0;
  endtask

  // Threshold 1 behaviour is obtained with drain=1, which pops whenever occupancy>0.
  task automatic do_reset();
    rst = 1'b1; sample_en = 1'b0; drain = 1'b0; out_ready = 1'b1;
    raw_mode = 1'b1; grp_en = 4'b0011;
    es_in = '0; src_valid = '0; src_fail = '0;
    step();
    rst = 1'b0;
    got_q.delete();
  endtask

  initial begin
    rst = 1'b1; sample_en = 1'b0; grp_en = '0; raw_mode = 1'b0; drain = 1'b0;
    out_ready = 1'b0; es_in = '0; src_valid = '0; src_fail = '0;
    step(); step();
    chk("rst_occupancy",  OW'(occupancy),  '0);
    chk("rst_ring_empty", OW'(ring_empty), OW'(1));
    chk("rst_ring_full",  OW'(ring_full),  '0);
    chk("rst_out_valid",  OW'(out_valid),  '0);
    chk("rst_out_data",   out_data,        '0);
    chk("rst_drop_cnt",   OW'(drop_cnt),   '0);

    // Full-good packing, alternating groups
    do_reset();
    drain = 1'b1;
    es_in = {32'h0, 32'h0, 32'h0F0F0F0F, 32'hA5A5A5A5};
    capture_n(8);
    idle(12);
    chk("pack_words", OW'(got_q.size()), OW'(2));
    if (got_q.size() >= 2) begin
      chk("pack_word0", got_q[0], 128'h0F0F0F0FA5A5A5A50F0F0F0FA5A5A5A5);
      chk("pack_word1", got_q[1], 128'h0F0F0F0FA5A5A5A50F0F0F0FA5A5A5A5);
    end
    chk("pack_drop", OW'(drop_cnt), '0);

    // Masked compaction: only the low 16 sources of group 0 are healthy
    do_reset();
    drain = 1'b1; raw_mode = 1'b0; grp_en = 4'b0001;
    es_in = {96'h0, 32'hDEADBEEF};
    src_valid = {96'h0, 32'h0000FFFF};
    capture_n(8);
    idle(12);
    chk("mask_words", OW'(got_q.size()), OW'(1));
    if (got_q.size() >= 1) chk("mask_word0", got_q[0], {8{16'hBEEF}});

    // Round-robin skip over disabled groups 0 and 2
    do_reset();
    drain = 1'b1; grp_en = 4'b1010;
    es_in = {32'h33333333, 32'h22222222, 32'h11111111, 32'hC0C0C0C0};
    capture_n(6);
    idle(12);
    chk("rr_words", OW'(got_q.size()), OW'(1));
    if (got_q.size() >= 1) chk("rr_word0", got_q[0], 128'h33333333111111113333333311111111);

    // Threshold holds reads, drain empties the ring
    do_reset();
    es_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    capture_n(10);
    idle(3);
    chk("thr_occupancy", OW'(occupancy), OW'(10));
    chk("thr_no_out",    OW'(out_valid), '0);
    drain = 1'b1;
    idle(20);
    chk("drain_occupancy", OW'(occupancy),  '0);
    chk("drain_empty",     OW'(ring_empty), OW'(1));
    chk("drain_words",     OW'(got_q.size()), OW'(2));

    // Overflow under a stalled consumer
    do_reset();
    out_ready = 1'b0; drain = 1'b1;
    es_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    capture_n(200);
    chk("ovf_full",      OW'(ring_full), OW'(1));
    chk("ovf_occupancy", OW'(occupancy), OW'(DP));
    chk("ovf_out_valid", OW'(out_valid), OW'(1));
    chk("ovf_drop",      OW'(drop_cnt),  OW'(200 - (DP + 1 + 4 + 4)));
    out_ready = 1'b1;
    idle(120);
    chk("ovf_flushed", OW'(ring_empty), OW'(1));

    // Reset mid-stream with 96 accumulated bits and 5 ring words
    do_reset();
    drain = 1'b1;
    es_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    capture_n(3);
    idle(4);
    drain = 1'b0;
    capture_n(5);
    idle(1);
    chk("mid_occupancy", OW'(occupancy), OW'(5));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_occupancy", OW'(occupancy),  '0);
    chk("mid_rst_out_valid", OW'(out_valid),  '0);
    chk("mid_rst_empty",     OW'(ring_empty), OW'(1));
    drain = 1'b1;
    capture_n(20);
    idle(20);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      rst       = ($urandom_range(0, 499) == 0);
      sample_en = ($urandom_range(0, 9) < 7);
      grp_en    = ($urandom_range(0, 19) == 0) ? '0 : NG'($urandom());
      raw_mode  = ($urandom_range(0, 3) == 0);
      drain     = ($urandom_range(0, 9) < 3);
      out_ready = ($urandom_range(0, 9) < 6);
      es_in     = {$urandom(), $urandom(), $urandom(), $urandom()};
      src_valid = {$urandom(), $urandom(), $urandom(), $urandom()};
      src_fail  = {$urandom() & $urandom() & $urandom(), $urandom() & $urandom() & $urandom(),
                   $urandom() & $urandom() & $urandom(), $urandom() & $urandom() & $urandom()};
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
